// File: rtl/perceptron_train_sequencer.sv
// Sequences stored samples through a perceptron: num_epochs training passes, then one
// scoring pass that counts how many predictions agree with the labels.
module perceptron_train_sequencer #(
  parameter int INPUT_UNITS = 2,
  parameter int MAX_SAMPLES = 8,
  parameter int EPOCH_W     = 16,
  localparam int AW = $clog2(MAX_SAMPLES),
  localparam int CW = AW + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_en,
  input  logic [AW-1:0]      load_idx,
  input  real                load_values [INPUT_UNITS],
  input  real                load_label,
  input  logic [CW-1:0]      num_samples,
  input  logic [EPOCH_W-1:0] num_epochs,
  input  logic               start,
  input  logic               abort,
  input  real                prediction,
  output real                values [INPUT_UNITS],
  output real                expected,
  output logic               training,
  output logic [EPOCH_W-1:0] epoch,
  output logic [AW-1:0]      sample_idx,
  output logic [CW-1:0]      correct,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    IDLE, TRAIN_APPLY, TRAIN_CAPTURE, TEST_APPLY, TEST_CAPTURE, DONE
  } state_t;

  localparam logic [CW-1:0] MAX_N = CW'(MAX_SAMPLES);

  state_t state, state_n;
  logic [CW-1:0]      n_lat, n_n, n_sat;
  logic [EPOCH_W-1:0] ne_lat, ne_n, epoch_n;
  logic [AW-1:0]      sidx_n;
  logic [CW-1:0]      corr_n;
  logic               done_n, last, hit, presenting;

  // Sample store is deliberately left out of reset
  real store_vals [MAX_SAMPLES][INPUT_UNITS];
  real store_lbl  [MAX_SAMPLES];

  assign busy       = (state != IDLE) && (state != DONE);
  assign training   = (state == TRAIN_APPLY) || (state == TRAIN_CAPTURE);
  assign presenting = busy;
  assign n_sat      = (num_samples > MAX_N) ? MAX_N : num_samples;
  assign last       = ({1'b0, sample_idx} + CW'(1)) == n_lat;
  // Exactly 0.5 classifies as 1 on both sides
  assign hit        = (prediction >= 0.5) == (expected >= 0.5);

  always_comb begin
    expected = 0.0;
    for (int i = 0; i < INPUT_UNITS; i++) values[i] = 0.0;
    if (presenting) begin
      expected = store_lbl[sample_idx];
      for (int i = 0; i < INPUT_UNITS; i++) values[i] = store_vals[sample_idx][i];
    end
  end

  always_ff @(posedge clk) begin
    if (load_en && !busy) begin
      store_lbl[load_idx] <= load_label;
      for (int i = 0; i < INPUT_UNITS; i++) store_vals[load_idx][i] <= load_values[i];
    end
  end

  always_comb begin
    state_n = state;
    n_n     = n_lat;
    ne_n    = ne_lat;
    sidx_n  = sample_idx;
    epoch_n = epoch;
    corr_n  = correct;
    done_n  = 1'b0;
    case (state)
      IDLE, DONE: if (start) begin
        n_n     = n_sat;
        ne_n    = num_epochs;
        sidx_n  = '0;
        epoch_n = '0;
        corr_n  = '0;
        if (n_sat == '0) begin
          state_n = DONE;
          done_n  = 1'b1;
        end else if (num_epochs == '0) state_n = TEST_APPLY;
        else                           state_n = TRAIN_APPLY;
      end
      TRAIN_APPLY:   state_n = TRAIN_CAPTURE;
      TRAIN_CAPTURE: if (!last) begin
        sidx_n  = sample_idx + AW'(1);
        state_n = TRAIN_APPLY;
      end else begin
        sidx_n  = '0;
        epoch_n = epoch + EPOCH_W'(1);
        state_n = (epoch_n < ne_lat) ? TRAIN_APPLY : TEST_APPLY;
      end
      TEST_APPLY:    state_n = TEST_CAPTURE;
      TEST_CAPTURE: begin
        if (hit) corr_n = correct + CW'(1);
        if (last) begin
          state_n = DONE;
          done_n  = 1'b1;
        end else begin
          sidx_n  = sample_idx + AW'(1);
          state_n = TEST_APPLY;
        end
      end
      default: state_n = IDLE;
    endcase
    if (abort) begin
      state_n = IDLE;
      done_n  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      n_lat      <= '0;
      ne_lat     <= '0;
      sample_idx <= '0;
      epoch      <= '0;
      correct    <= '0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      n_lat      <= n_n;
      ne_lat     <= ne_n;
      sample_idx <= sidx_n;
      epoch      <= epoch_n;
      correct    <= corr_n;
      done       <= done_n;
    end
  end

endmodule

// File: tb/tb_perceptron_train_sequencer.sv
// Directed bench: AND table against a hand-trained perceptron, plus edge cases.
module tb_perceptron_train_sequencer;
  logic        clk = 0, rst = 1;
  logic        load_en = 0, start = 0, abort = 0;
  logic [2:0]  load_idx = 0;
  real         load_values [2];
  real         load_label = 0.0;
  logic [3:0]  num_samples = 0;
  logic [15:0] num_epochs = 0;
  real         prediction;
  real         values [2];
  real         expected;
  logic        training, busy, done;
  logic [15:0] epoch;
  logic [2:0]  sample_idx;
  logic [3:0]  correct;

  perceptron_train_sequencer dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_idx(load_idx),
    .load_values(load_values), .load_label(load_label), .num_samples(num_samples),
    .num_epochs(num_epochs), .start(start), .abort(abort), .prediction(prediction),
    .values(values), .expected(expected), .training(training), .epoch(epoch),
    .sample_idx(sample_idx), .correct(correct), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Trained AND perceptron (w=1,1 b=-1.5), or a fixed output when fixed_pred is set
  logic fixed_pred = 0;
  real  pred_const = 0.0;
  always_comb begin
    if (fixed_pred) prediction = pred_const;
    else            prediction = (values[0] + values[1] - 1.5 >= 0.0) ? 1.0 : 0.0;
  end

  int busy_cnt, done_cnt;
  logic train_seen;
  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (training) train_seen = 1'b1;
  end

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic longint milli(input real r);
    return longint'($rtoi(r * 1000.0));
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load(input int idx, input real a, input real b, input real lbl);
    load_en = 1; load_idx = 3'(idx);
    load_values[0] = a; load_values[1] = b; load_label = lbl;
    tick();
    load_en = 0;
  endtask

  task automatic kick(input int ns, input int ne);
    num_samples = 4'(ns); num_epochs = 16'(ne);
    busy_cnt = 0; done_cnt = 0; train_seen = 0;
    start = 1; tick(); start = 0;
  endtask

  // Waits for done; returns cycles waited after the start edge, -1 on timeout
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 2000) begin tick(); cyc++; end
    if (!done) begin chk("done_timeout", 0, 1); cyc = -1; end
    tick(); tick();
  endtask

  int cyc;

  initial begin
    load_values[0] = 0.0; load_values[1] = 0.0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_training", training, 0);
    chk("rst_epoch", epoch, 0);
    chk("rst_correct", correct, 0);
    chk("rst_expected", milli(expected), 0);
    rst = 0; tick();

    load(0, 0.0, 0.0, 0.0); load(1, 0.0, 1.0, 0.0);
    load(2, 1.0, 0.0, 0.0); load(3, 1.0, 1.0, 1.0);

    // Full training run
    kick(4, 100);
    chk("and_first_training", training, 1);
    chk("and_first_idx", sample_idx, 0);
    tick(); tick(); tick();
    chk("and_s1_values1", milli(values[1]), 1000);
    chk("and_s1_expected", milli(expected), 0);
    wait_done(cyc);
    chk("and_busy", busy_cnt, 808);
    chk("and_epoch", epoch, 100);
    chk("and_done_pulses", done_cnt, 1);
    chk("and_correct", correct, 4);
    chk("and_done_idle_values", milli(values[0]), 0);

    // Scoring only
    kick(4, 0);
    wait_done(cyc);
    chk("e0_training", train_seen, 0);
    chk("e0_busy", busy_cnt, 8);
    chk("e0_done_pulses", done_cnt, 1);
    chk("e0_correct", correct, 4);

    // No samples
    kick(0, 5);
    chk("n0_done_next", done, 1);
    chk("n0_correct", correct, 0);
    wait_done(cyc);
    chk("n0_busy", busy_cnt, 0);

    // Abort beats start in IDLE/DONE
    abort = 1; start = 1; tick(); abort = 0; start = 0;
    chk("abort_prio_busy", busy, 0);

    // Abort in epoch 3
    kick(4, 10);
    cyc = 0;
    while (epoch != 3 && cyc < 500) begin tick(); cyc++; end
    chk("abort_reach_e3", epoch, 3);
    done_cnt = 0;
    abort = 1; tick(); abort = 0;
    chk("abort_busy", busy, 0);
    chk("abort_training", training, 0);
    chk("abort_done", done, 0);
    tick(); tick();
    chk("abort_no_done", done_cnt, 0);
    kick(4, 10);
    chk("rerun_epoch", epoch, 0);
    chk("rerun_training", training, 1);
    wait_done(cyc);
    chk("rerun_final_epoch", epoch, 10);

    // Write while busy is dropped; reset during TEST_CAPTURE
    kick(4, 1);
    load(3, 1.0, 1.0, 0.0);
    cyc = 0;
    while (!(busy && !training) && cyc < 100) begin tick(); cyc++; end
    chk("reach_test_apply", busy && !training, 1);
    tick();
    rst = 1; tick();
    chk("rstmid_busy", busy, 0);
    chk("rstmid_training", training, 0);
    chk("rstmid_epoch", epoch, 0);
    chk("rstmid_idx", sample_idx, 0);
    chk("rstmid_correct", correct, 0);
    chk("rstmid_expected", milli(expected), 0);
    chk("rstmid_values0", milli(values[0]), 0);
    rst = 0; tick();
    kick(4, 0);
    wait_done(cyc);
    chk("store_kept_correct", correct, 4);

    // Sample count saturates at store depth
    kick(15, 0);
    wait_done(cyc);
    chk("sat_busy", busy_cnt, 16);

    // 0.5 threshold
    fixed_pred = 1; pred_const = 0.5;
    load(0, 0.0, 0.0, 1.0);
    kick(1, 0);
    wait_done(cyc);
    chk("half_vs_1", correct, 1);
    load(0, 0.0, 0.0, 0.0);
    kick(1, 0);
    wait_done(cyc);
    chk("half_vs_0", correct, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/perceptron_train_sequencer.md
PERCEPTRON_TRAIN_SEQUENCER -- requirements
Module: perceptron_train_sequencer

Interface
REQ-001 The module SHALL have parameter INPUT_UNITS, default 2, the number of inputs per sample.
REQ-002 The module SHALL have parameter MAX_SAMPLES, default 8, the sample-store depth.
REQ-003 The module SHALL have parameter EPOCH_W, default 16, the width of the epoch count and counter.
REQ-004 The module SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The module SHALL have port rst, input, 1, the reset; synchronous and active-high.
REQ-006 The module SHALL have port load_en, input, 1, which writes one sample-store entry.
REQ-007 The module SHALL have port load_idx, input, $clog2(MAX_SAMPLES), the entry written.
REQ-008 The module SHALL have port load_values, input, real[INPUT_UNITS], the sample inputs written.
REQ-009 The module SHALL have port load_label, input, real, the sample's expected output written.
REQ-010 The module SHALL have port num_samples, input, $clog2(MAX_SAMPLES)+1, the active sample count, sampled at start.
REQ-011 The module SHALL have port num_epochs, input, EPOCH_W, the training epoch count, sampled at start.
REQ-012 The module SHALL have port start, input, 1, a single-cycle run request.
REQ-013 The module SHALL have port abort, input, 1, which cancels a run.
REQ-014 The module SHALL have port prediction, input, real, the perceptron output.
REQ-015 The module SHALL have port values, output, real[INPUT_UNITS], driven to the perceptron inputs.
REQ-016 The module SHALL have port expected, output, real, the current sample's label.
REQ-017 The module SHALL have port training, output, 1, driven to the perceptron training enable.
REQ-018 The module SHALL have outputs epoch (EPOCH_W), sample_idx ($clog2(MAX_SAMPLES)), correct ($clog2(MAX_SAMPLES)+1), busy (1) and done (1).

Function
REQ-019 The FSM SHALL have states IDLE, TRAIN_APPLY, TRAIN_CAPTURE, TEST_APPLY, TEST_CAPTURE and DONE.
REQ-020 load_en SHALL write the store only in IDLE or DONE; a write while busy SHALL be ignored.
REQ-021 In IDLE or DONE, start SHALL latch num_samples and num_epochs, clear epoch, sample_idx and correct, and go to TRAIN_APPLY.
REQ-022 If the latched num_epochs is 0, start SHALL go to TEST_APPLY instead.
REQ-023 If the latched num_samples is 0, start SHALL go directly to DONE with correct=0.
REQ-024 num_samples values above MAX_SAMPLES SHALL be saturated to MAX_SAMPLES.
REQ-025 In any APPLY state, values and expected SHALL equal store[sample_idx] during that cycle.
REQ-026 Each APPLY state SHALL last exactly one cycle and be followed by its CAPTURE state.
REQ-027 values and expected SHALL remain held through the CAPTURE cycle, giving 2 cycles per sample.
REQ-028 training SHALL be 1 in TRAIN_APPLY and TRAIN_CAPTURE, and 0 in every other state.
REQ-029 In TRAIN_CAPTURE, if sample_idx < n-1, sample_idx SHALL increment and the FSM SHALL go to TRAIN_APPLY.
REQ-030 In TRAIN_CAPTURE with the last sample, sample_idx SHALL be cleared and epoch incremented.
REQ-031 After that increment, the FSM SHALL go to TRAIN_APPLY if epoch < num_epochs, else to TEST_APPLY.
REQ-032 In TEST_CAPTURE, correct SHALL increment when (prediction >= 0.5) == (expected >= 0.5); exactly 0.5 classifies as 1.
REQ-033 After the last sample's TEST_CAPTURE, the FSM SHALL go to DONE; otherwise sample_idx SHALL increment and the FSM SHALL go to TEST_APPLY.
REQ-034 busy SHALL be 1 in every state except IDLE and DONE.
REQ-035 done SHALL be 1 for exactly the first cycle in DONE; the FSM, correct and epoch then hold until the next start.
REQ-036 start while busy SHALL be ignored.
REQ-037 abort SHALL return the FSM to IDLE on the next edge with training=0 and done not asserted; abort has priority over start.
REQ-038 abort SHALL leave the store unchanged.
REQ-039 In IDLE and DONE, values and expected SHALL be 0.0.
REQ-040 A full run SHALL take 2*n*(num_epochs+1) busy cycles.

Reset
REQ-041 rst=1 at a clock edge SHALL force IDLE and zero values, expected, training, epoch, sample_idx, correct, busy and done, including mid-run.
REQ-042 Reset SHALL not clear the sample store; stored contents are undefined until written.

Verification
REQ-043 Load the AND table {[0,0]:0,[0,1]:0,[1,0]:0,[1,1]:1}, n=4, epochs=100, driving a trained perceptron -> busy for 808 cycles, epoch=100, done pulses once, correct=4.
REQ-044 With n=4 and epochs=0 -> training stays 0 throughout, busy for 8 cycles, then done.
REQ-045 With n=0 -> done one cycle after start, correct=0, busy never 1.
REQ-046 Assert abort during epoch 3 -> IDLE next cycle with training=0 and no done; a following start reruns from epoch=0.
REQ-047 Assert rst during TEST_CAPTURE -> all outputs 0 and state IDLE; load_en while busy leaves store contents unchanged.
REQ-048 Drive prediction=0.5 against label 1.0 -> counted correct; against label 0.0 -> not counted.
